spike_arb_fifo: RTL

//  Converts a wide per-timestep spike vector into a serial stream of address

---
 rtl/spike_arb_fifo_pkg.sv | 15 +
 rtl/spike_arb_fifo_sync_fifo.sv | 63 ++++++
 rtl/spike_arb_fifo.sv | 127 ++++++++++++
 3 files changed

// File: rtl/spike_arb_fifo_pkg.sv
// Shared types and helpers for the spike arbiter / event FIFO.
//   arb_mode_e : arbitration policy (fixed lowest-index-first, or round-robin)
//   idx_w(n)   : width needed to hold a neuron index in 0..n-1
package spike_arb_fifo_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/spike_arb_fifo_sync_fifo.sv
// Count-based synchronous FIFO with combinational read port.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (control state only)
//   push, din     write request and data; honoured when not full, or when a
//                 pop happens in the same cycle
//   pop, dout     read request and head data; pop on empty is ignored,
//                 dout reads 0 while empty
//   count         occupancy 0..DEPTH
//   full, empty   occupancy flags
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  // A pop frees the slot this cycle, so a full FIFO can still accept a push.
  assign push_ok = push & (~full | pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spike_arb_fifo.sv
// Spike vector to address-event serialiser.
// Accepts a wide spike vector, then grants one set bit per cycle (fixed or
// round-robin priority) and pushes its index into an event FIFO.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   in_valid     spike vector valid; accepted when in_ready is high
//   in_ready     high while no vector is pending (IDLE)
//   in_spikes    bit i set = neuron i fired
//   out_valid    FIFO head valid
//   out_ready    consumer pops head when out_valid & out_ready
//   out_idx      neuron index at FIFO head
//   fifo_count   FIFO occupancy
//   busy         a pending vector is still being drained into the FIFO
module spike_arb_fifo
  import spike_arb_fifo_pkg::*;
#(
  parameter int N_IN  = 961,
  parameter int DEPTH = 8,
  parameter int MODE  = 0,
  parameter int IDX_W = idx_w(N_IN)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_IN-1:0]            in_spikes,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IDX_W-1:0]           out_idx,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       busy
);

  localparam arb_mode_e ARB = (MODE == 1) ? ARB_RR : ARB_FIXED;

  typedef enum logic {S_IDLE, S_SCAN} state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } grant_t;

  // First set bit of vec at or above start, wrapping N_IN-1 -> 0.
  // With start fixed at 0 this is a plain lowest-index priority encoder.
  function automatic grant_t pick(input logic [N_IN-1:0] vec,
                                  input logic [IDX_W-1:0] start);
    grant_t g;
    int     j;
    g = '0;
    for (int k = 0; k < N_IN; k++) begin
      j = int'(start) + k;
      if (j >= N_IN) j = j - N_IN;
      if (vec[j] && !g.found) begin
        g.found = 1'b1;
        g.idx   = IDX_W'(j);
      end
    end
    return g;
  endfunction

  state_e           state;
  logic [N_IN-1:0]  pending;
  logic [N_IN-1:0]  pending_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_ptr_nxt;
  logic [IDX_W-1:0] scan_start;
  grant_t           grant;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  assign in_ready   = (state == S_IDLE);
  assign busy       = (state == S_SCAN);
  assign out_valid  = ~fifo_empty;
  assign pop        = out_valid & out_ready;
  assign scan_start = (ARB == ARB_RR) ? rr_ptr : '0;
  assign grant      = pick(pending, scan_start);
  // Stall (keep the bit pending) when the FIFO is full and nothing leaves.
  assign push       = (state == S_SCAN) & grant.found & (~fifo_full | pop);
  assign rr_ptr_nxt = (grant.idx == IDX_W'(N_IN-1)) ? '0 : grant.idx + 1'b1;

  always_comb begin
    pending_nxt = pending;
    if (push) pending_nxt[grant.idx] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pending <= '0;
      rr_ptr  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // An all-zero vector is consumed without leaving IDLE.
          if (in_valid) begin
            pending <= in_spikes;
            state   <= (|in_spikes) ? S_SCAN : S_IDLE;
          end
        end
        S_SCAN: begin
          pending <= pending_nxt;
          if (push) rr_ptr <= rr_ptr_nxt;
          if (pending_nxt == '0) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .W     (IDX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (grant.idx),
    .pop   (pop),
    .dout  (out_idx),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
